// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle processor main control FSM with retired-instruction counter
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             PCWrite,
    output logic             Branch,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    logic             op_bad;

    assign state       = state_q;
    assign instr_count = count_q;

    // State and retired-instruction counter registers; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state selection, retirement detection and Moore output decode
    always_comb begin
        state_d    = S_FETCH;
        retire     = 1'b0;
        op_bad     = 1'b0;
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        op_bad  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
                illegal_op = op_bad;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (op == OP_LW)
                    state_d = S_MEMRD;
                else if (op == OP_SW)
                    state_d = S_MEMWR;
                else
                    state_d = S_FETCH;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
                retire  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_JEX: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        count_d = retire ? count_q + CNT_W'(1) : count_q;

        // Strobes are held low for as long as reset is asserted
        if (reset) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        mem_ready;

    logic        mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
    logic        PCWrite, Branch, illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic        mem_req4, IorD4, MemWrite4, IRWrite4, RegDst4, MemtoReg4, RegWrite4, ALUSrcA4;
    logic [1:0]  ALUSrcB4, ALUOp4, PCSrc4;
    logic        PCWrite4, Branch4, illegal_op4;
    logic [3:0]  state4;
    logic [3:0]  instr_count4;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .Branch(Branch), .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req4), .IorD(IorD4), .MemWrite(MemWrite4), .IRWrite(IRWrite4),
        .RegDst(RegDst4), .MemtoReg(MemtoReg4), .RegWrite(RegWrite4), .ALUSrcA(ALUSrcA4),
        .ALUSrcB(ALUSrcB4), .ALUOp(ALUOp4), .PCSrc(PCSrc4), .PCWrite(PCWrite4),
        .Branch(Branch4), .illegal_op(illegal_op4), .state(state4), .instr_count(instr_count4)
    );

    // {mem_req,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCWrite,Branch,illegal_op}
    function automatic logic [16:0] dut_ctrl();
        return {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, illegal_op};
    endfunction

    // Control word the specification's per-state table calls for
    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic bad);
        logic mr, iod, mw, irw, rd, m2r, rw, sa, pcw, br, ill;
        logic [1:0] sb, ao, ps;
        {mr, iod, mw, irw, rd, m2r, rw, sa, pcw, br, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; ill = bad; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mr = 1; iod = 1; mw = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; end
            11: begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {mr, iod, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pcw, br, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive mem_ready at the falling edge, check everything, wait for the next falling edge
    task automatic step(input int st, input logic rdy, input logic bad);
        logic [31:0] mc;
        mem_ready = rdy;
        #1;
        mc = model_count;
        chk($sformatf("state(exp %0d)", st), 32'(state), 32'(st));
        chk($sformatf("ctrl(st %0d)", st), 32'(dut_ctrl()), 32'(exp_ctrl(st, rdy, bad)));
        chk("instr_count", instr_count, mc);
        chk("instr_count4", 32'(instr_count4), 32'(mc[3:0]));
        chk("state4", 32'(state4), 32'(st));
        @(negedge clk);
    endtask

    function automatic logic legal(input logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Instruction-level model: path of states implied by the opcode, with memory wait cycles
    task automatic run_instr(input logic [5:0] opc, input int fw, input int mw);
        op = opc;
        repeat (fw) step(0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0);
        if (!legal(opc)) begin
            step(1, 1'($urandom), 1'b1);
            return;
        end
        step(1, 1'($urandom), 1'b0);
        case (opc)
            6'b100011: begin
                step(2, 1'($urandom), 1'b0);
                repeat (mw) step(3, 1'b0, 1'b0);
                step(3, 1'b1, 1'b0);
                step(4, 1'($urandom), 1'b0);
            end
            6'b101011: begin
                step(2, 1'($urandom), 1'b0);
                repeat (mw) step(5, 1'b0, 1'b0);
                step(5, 1'b1, 1'b0);
            end
            6'b000000: begin step(6, 1'($urandom), 1'b0); step(7, 1'($urandom), 1'b0); end
            6'b000100: step(8, 1'($urandom), 1'b0);
            6'b001000: begin step(9, 1'($urandom), 1'b0); step(10, 1'($urandom), 1'b0); end
            default:   step(11, 1'($urandom), 1'b0);
        endcase
        model_count++;
    endtask

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        reset = 1'b1;
        op = 6'b000000;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset strobes", 32'(dut_ctrl() & 17'b10110010000001110), 32'd0);
        chk("reset count", instr_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-type with memory always ready
        run_instr(6'b000000, 0, 0);
        // lw with three stalled cycles in MEMRD
        run_instr(6'b100011, 0, 3);
        // sw with two stalled cycles, MemWrite held three cycles
        run_instr(6'b101011, 1, 2);
        // beq then j back to back
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        // illegal opcode returns without retiring
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001000, 2, 0);

        // asynchronous reset in the middle of RTYPEEX
        op = 6'b000000;
        step(0, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0);
        mem_ready = 1'b1;
        #1;
        chk("pre-reset state", 32'(state), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        model_count = 0;
        chk("async reset state", 32'(state), 32'd0);
        chk("async reset RegWrite", 32'(RegWrite), 32'd0);
        chk("async reset strobes", 32'(dut_ctrl() & 17'b10110010000001110), 32'd0);
        chk("async reset count", instr_count, 32'd0);
        @(negedge clk);
        #1;
        chk("held reset RegWrite", 32'(RegWrite), 32'd0);
        chk("held reset state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // sixteen jumps wrap the 4-bit counter back to zero
        repeat (16) run_instr(6'b000010, 0, 0);
        mem_ready = 1'b0;
        #1;
        chk("wrap count4", 32'(instr_count4), 32'd0);
        chk("no-wrap count32", instr_count, 32'd16);
        @(negedge clk);

        // randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            logic [5:0] o;
            if ($urandom_range(0, 4) == 0) o = 6'($urandom);
            else                           o = legal_ops[$urandom_range(0, 5)];
            run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle variant of the processor. It sequences a shared ALU, a single instruction/data memory port and the register file across several cycles per instruction. Its ALUOp output drives the existing ALU-control decoder: 00 = add, 01 = subtract, 10 = decode funct. It also handshakes with memory through mem_req/mem_ready and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter instr_count.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
op  input  6  opcode field from the instruction register (IR[31:26]).
mem_ready  input  1  memory has completed the current request this cycle.
mem_req  output  1  memory access request.
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  instruction register load.
RegDst  output  1  write-register select: 0 = rt, 1 = rd.
MemtoReg  output  1  write-data select: 0 = ALUOut, 1 = MDR.
RegWrite  output  1  register file write enable.
ALUSrcA  output  1  ALU A input: 0 = PC, 1 = register A.
ALUSrcB  output  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
ALUOp  output  2  to the ALU-control decoder.
PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
PCWrite  output  1  unconditional PC write.
Branch  output  1  conditional PC write (datapath ANDs it with Zero).
illegal_op  output  1  one-cycle flag: undefined opcode was decoded.
state  output  4  current state encoding, for debug.
instr_count  output  CNT_W  number of retired instructions.

Behaviour:
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010. Any other value is illegal.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- Outputs are Moore, decoded from the state, except IRWrite and PCWrite in FETCH, which are gated by mem_ready. Any output not listed for a state is 0.
- Reset: while reset is high, state = FETCH, instr_count = 0, and every strobe is forced to 0 (mem_req, MemWrite, IRWrite, RegWrite, PCWrite, Branch, illegal_op). Reset asserted mid-instruction aborts it; no partial writes occur after reset asserts.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=mem_ready, PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by op:
  - lw or sw -> MEMADR; R-type -> RTYPEEX; beq -> BEQEX; addi -> ADDIEX; j -> JEX.
  - Illegal op -> FETCH with illegal_op=1 for this cycle only.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, IorD=1. Stays until mem_ready=1, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. -> FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1, held until mem_ready=1. -> FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RTYPEWB.
- RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1. -> FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. -> FETCH.
- JEX: PCSrc=10, PCWrite=1. -> FETCH.
- Unused encodings 12-15 -> FETCH on the next edge, with all strobes 0.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB or JEX. It does not increment on an illegal-op return or on a stay in FETCH. It wraps modulo 2^CNT_W.
- Latency with mem_ready tied to 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.

Test Plan:
- Reset then release with mem_ready=1 and op=000000 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; ALUOp=10 in state 6; instr_count=1.
- lw with mem_ready=0 for 3 cycles in MEMRD -> state holds 3 with mem_req=1, IorD=1 and no RegWrite; after mem_ready rises, state goes 4 (MemtoReg=1, RegWrite=1) then 0.
- sw with mem_ready delayed 2 cycles -> MemWrite=1 for exactly 3 cycles in state 5, then FETCH; instr_count increments once.
- beq then j back-to-back -> BEQEX shows ALUOp=01, Branch=1, PCSrc=01; JEX shows PCWrite=1, PCSrc=10; instr_count +2.
- op=111111 in DECODE -> illegal_op=1 for one cycle, next state FETCH, instr_count unchanged.
- Reset asserted asynchronously in RTYPEEX -> state=0 and RegWrite=0 immediately, no write-back; instr_count=0.
- CNT_W=4, 16 j instructions -> instr_count wraps to 0.
